// File: rtl/byte_deserializer.sv
// Assembles 8 consecutive bytes into a 64-bit word and queues it in a 2-entry output FIFO.
// Optional per-word XOR checksum on word_chk when BYTE_CHECKSUM_EN is defined.
module byte_deserializer (
  input  logic        clk_out,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [7:0]  data_in,
  input  logic        word_ready,
  output logic        word_valid,
  output logic [63:0] word_out,
  output logic        err_short,
  output logic        err_overflow
`ifdef BYTE_CHECKSUM_EN
  ,
  output logic [7:0]  word_chk
`endif
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned ACC_W  = WORD_W - BYTE_W;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned IDX_W  = 6;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               store_c;
  logic               push_c;
  logic               abort_c;
  logic               pop_c;
  logic [IDX_W-1:0]   idx_c;
  logic [ACC_W-1:0]   acc_q;
  logic [WORD_W-1:0]  new_word_c;
  logic [WORD_W-1:0]  mem1_q;
  logic               full_q;

  // FSM state register
  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: the 8th byte pushes directly from data_in, so a new frame may start next cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store_c = 1'b0;
    push_c  = 1'b0;
    abort_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          store_c = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (valid_in) begin
          if (cnt_q == CNT_W'(7)) begin
            push_c  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            store_c = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else begin
          abort_c = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign idx_c      = {cnt_q, 3'b000};
  assign new_word_c = {data_in, acc_q};
  assign pop_c      = word_ready & word_valid;

  // Byte accumulator for bytes 0..6; stale bytes are always overwritten before the next push
  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (store_c) begin
      acc_q[idx_c +: BYTE_W] <= data_in;
    end
  end

  // Shift-style FIFO: entry 0 drives word_out directly and is zeroed whenever it empties
  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      word_valid   <= 1'b0;
      full_q       <= 1'b0;
      word_out     <= '0;
      mem1_q       <= '0;
      err_short    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_short    <= abort_c;
      err_overflow <= push_c & ~pop_c & full_q;
      if (pop_c) begin
        if (push_c) begin
          if (full_q) begin
            word_out <= mem1_q;
            mem1_q   <= new_word_c;
          end else begin
            word_out <= new_word_c;
          end
        end else begin
          word_out   <= full_q ? mem1_q : '0;
          mem1_q     <= '0;
          word_valid <= full_q;
          full_q     <= 1'b0;
        end
      end else if (push_c) begin
        if (!word_valid) begin
          word_out   <= new_word_c;
          word_valid <= 1'b1;
        end else if (!full_q) begin
          mem1_q <= new_word_c;
          full_q <= 1'b1;
        end
      end
    end
  end

`ifdef BYTE_CHECKSUM_EN
  logic [BYTE_W-1:0] chk_acc_q;
  logic [BYTE_W-1:0] chk1_q;
  logic [BYTE_W-1:0] new_chk_c;

  assign new_chk_c = chk_acc_q ^ data_in;

  // Running XOR of the frame; restarts on byte 0
  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      chk_acc_q <= '0;
    end else if (store_c) begin
      chk_acc_q <= (state_q == IDLE) ? data_in : new_chk_c;
    end
  end

  // Checksum lanes follow exactly the same moves as the word entries
  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      word_chk <= '0;
      chk1_q   <= '0;
    end else begin
      if (pop_c) begin
        if (push_c) begin
          if (full_q) begin
            word_chk <= chk1_q;
            chk1_q   <= new_chk_c;
          end else begin
            word_chk <= new_chk_c;
          end
        end else begin
          word_chk <= full_q ? chk1_q : '0;
          chk1_q   <= '0;
        end
      end else if (push_c) begin
        if (!word_valid) begin
          word_chk <= new_chk_c;
        end else if (!full_q) begin
          chk1_q <= new_chk_c;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_byte_deserializer.sv
// Scoreboard bench for byte_deserializer: stimulus pushes hand-written expected words,
// a negedge monitor pops and compares on every accepted output word.
module tb_byte_deserializer;

  logic        clk_out;
  logic        rst;
  logic        valid_in;
  logic [7:0]  data_in;
  logic        word_ready;
  logic        word_valid;
  logic [63:0] word_out;
  logic        err_short;
  logic        err_overflow;
`ifdef BYTE_CHECKSUM_EN
  logic [7:0]  word_chk;
`endif

  byte_deserializer dut (
    .clk_out      (clk_out),
    .rst          (rst),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .word_ready   (word_ready),
    .word_valid   (word_valid),
    .word_out     (word_out),
    .err_short    (err_short),
    .err_overflow (err_overflow)
`ifdef BYTE_CHECKSUM_EN
    ,
    .word_chk     (word_chk)
`endif
  );

  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  int tests = 0;
  int fails = 0;
  int pop_cnt = 0;
  int short_cnt = 0;
  int ovf_cnt = 0;
  logic short_prev = 1'b0;
  logic ovf_prev = 1'b0;
  logic [63:0] exp_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xor8(input logic [63:0] w);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = r ^ w[8*k +: 8];
    return r;
  endfunction

  // Monitor: compare every accepted word against the scoreboard, count error pulses
  always @(negedge clk_out) begin
    if (rst) begin
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h expected none", word_out);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("word_out", word_out, e);
`ifdef BYTE_CHECKSUM_EN
          check("word_chk", 64'(word_chk), 64'(xor8(e)));
`endif
        end
        pop_cnt++;
      end
      if (!word_valid) check("idle_word_zero", word_out, 64'h0);
      if (err_short) short_cnt++;
      if (err_overflow) ovf_cnt++;
      if (err_short && short_prev) check("err_short_double", 64'(1), 64'(0));
      if (err_overflow && ovf_prev) check("err_ovf_double", 64'(1), 64'(0));
      short_prev = err_short;
      ovf_prev   = err_overflow;
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    valid_in   = v;
    data_in    = d;
    word_ready = r;
    @(posedge clk_out);
    #1;
  endtask

  task automatic send_frame(input logic [63:0] w, input logic r, input logic r_last);
    for (int k = 0; k < 8; k++) cyc(1'b1, w[8*k +: 8], (k == 7) ? r_last : r);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, s0, o0;
    rst = 1'b0; valid_in = 1'b0; data_in = 8'h00; word_ready = 1'b0;
    repeat (3) @(posedge clk_out);
    #1;
    check("rst_word_valid", 64'(word_valid), 64'(0));
    check("rst_word_out", word_out, 64'h0);
    check("rst_err_short", 64'(err_short), 64'(0));
    check("rst_err_ovf", 64'(err_overflow), 64'(0));
    rst = 1'b1;

    // Basic frame, latency 1
    p0 = pop_cnt;
    exp_q.push_back(64'h8877665544332211);
    send_frame(64'h8877665544332211, 1'b1, 1'b1);
    check("latency_valid", 64'(word_valid), 64'(1));
    check("latency_word", word_out, 64'h8877665544332211);
`ifdef BYTE_CHECKSUM_EN
    check("chk_0x88", 64'(word_chk), 64'h88);
`endif
    idle(3, 1'b1);
    check("t1_pops", 64'(pop_cnt - p0), 64'(1));

    // Back-to-back frames
    p0 = pop_cnt;
    exp_q.push_back(64'hF0E1D2C3B4A59687);
    exp_q.push_back(64'h0123456789ABCDEF);
    send_frame(64'hF0E1D2C3B4A59687, 1'b1, 1'b1);
    send_frame(64'h0123456789ABCDEF, 1'b1, 1'b1);
    idle(4, 1'b1);
    check("b2b_pops", 64'(pop_cnt - p0), 64'(2));

    // Short frame
    p0 = pop_cnt; s0 = short_cnt;
    cyc(1'b1, 8'hAA, 1'b1);
    cyc(1'b1, 8'hBB, 1'b1);
    cyc(1'b1, 8'hCC, 1'b1);
    idle(1, 1'b1);
    check("err_short_pulse", 64'(err_short), 64'(1));
    check("short_no_valid", 64'(word_valid), 64'(0));
    idle(1, 1'b1);
    check("err_short_low", 64'(err_short), 64'(0));
    idle(2, 1'b1);
    check("short_cnt", 64'(short_cnt - s0), 64'(1));
    check("short_no_pop", 64'(pop_cnt - p0), 64'(0));
    exp_q.push_back(64'h1F2E3D4C5B6A7988);
    send_frame(64'h1F2E3D4C5B6A7988, 1'b1, 1'b1);
    idle(3, 1'b1);
    check("after_short_pops", 64'(pop_cnt - p0), 64'(1));

    // Overflow: third frame dropped
    p0 = pop_cnt; o0 = ovf_cnt;
    exp_q.push_back(64'h0807060504030201);
    exp_q.push_back(64'h1817161514131211);
    send_frame(64'h0807060504030201, 1'b0, 1'b0);
    send_frame(64'h1817161514131211, 1'b0, 1'b0);
    send_frame(64'h2827262524232221, 1'b0, 1'b0);
    check("ovf_pulse", 64'(err_overflow), 64'(1));
    idle(1, 1'b0);
    check("ovf_low", 64'(err_overflow), 64'(0));
    check("ovf_head", word_out, 64'h0807060504030201);
    idle(2, 1'b0);
    check("ovf_cnt", 64'(ovf_cnt - o0), 64'(1));
    check("ovf_held", 64'(pop_cnt - p0), 64'(0));
    idle(4, 1'b1);
    check("ovf_drain_pops", 64'(pop_cnt - p0), 64'(2));
    check("ovf_drained", 64'(word_valid), 64'(0));

    // Full FIFO, pop coincides with push
    p0 = pop_cnt; o0 = ovf_cnt;
    exp_q.push_back(64'hA1A2A3A4A5A6A7A8);
    exp_q.push_back(64'hB1B2B3B4B5B6B7B8);
    exp_q.push_back(64'hC1C2C3C4C5C6C7C8);
    send_frame(64'hA1A2A3A4A5A6A7A8, 1'b0, 1'b0);
    send_frame(64'hB1B2B3B4B5B6B7B8, 1'b0, 1'b0);
    send_frame(64'hC1C2C3C4C5C6C7C8, 1'b0, 1'b1);
    check("pp_no_ovf", 64'(err_overflow), 64'(0));
    check("pp_head", word_out, 64'hB1B2B3B4B5B6B7B8);
    check("pp_one_pop", 64'(pop_cnt - p0), 64'(1));
    idle(2, 1'b0);
    check("pp_ovf_cnt", 64'(ovf_cnt - o0), 64'(0));
    idle(4, 1'b1);
    check("pp_drain_pops", 64'(pop_cnt - p0), 64'(3));

    // Reset mid-frame with a word queued
    s0 = short_cnt; o0 = ovf_cnt;
    send_frame(64'hD1D2D3D4D5D6D7D8, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'h30 + k), 1'b0);
    valid_in = 1'b0;
    rst = 1'b0;
    #2;
    check("mid_rst_valid", 64'(word_valid), 64'(0));
    check("mid_rst_word", word_out, 64'h0);
    check("mid_rst_short", 64'(err_short), 64'(0));
    check("mid_rst_ovf", 64'(err_overflow), 64'(0));
`ifdef BYTE_CHECKSUM_EN
    check("mid_rst_chk", 64'(word_chk), 64'h0);
`endif
    exp_q.delete();
    @(posedge clk_out);
    @(posedge clk_out);
    #1;
    rst = 1'b1;
    p0 = pop_cnt;
    exp_q.push_back(64'hE8E7E6E5E4E3E2E1);
    send_frame(64'hE8E7E6E5E4E3E2E1, 1'b1, 1'b1);
    idle(3, 1'b1);
    check("post_rst_pops", 64'(pop_cnt - p0), 64'(1));
    check("post_rst_no_short", 64'(short_cnt - s0), 64'(0));
    check("post_rst_no_ovf", 64'(ovf_cnt - o0), 64'(0));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/byte_deserializer.md
BYTE_DESERIALIZER -- requirements
Module: byte_deserializer

Interface
REQ-001 Parameters: none; widths fixed at 8-bit byte in, 64-bit word out (8 bytes per word).
REQ-002 clk_out  input  1  sole clock; all state on its rising edge.
REQ-003 rst  input  1  one clock; reset is asynchronous and active-low; asserted when 0.
REQ-004 valid_in  input  1  byte qualifier; one byte per cycle while high.
REQ-005 data_in  input  8  byte data; first byte of a frame is word bits [7:0].
REQ-006 word_ready  input  1  downstream accepts word_out this cycle when high with word_valid.
REQ-007 word_valid  output  1  high while the output FIFO is non-empty.
REQ-008 word_out  output  64  FIFO head word; 0 when word_valid is low.
REQ-009 err_short  output  1  one-cycle pulse: frame aborted before 8 bytes.
REQ-010 err_overflow  output  1  one-cycle pulse: complete frame dropped, FIFO full.
REQ-011 word_chk  output  8  XOR of the 8 bytes of word_out (only with BYTE_CHECKSUM_EN).

Function
REQ-012 The block SHALL assemble bursts of exactly 8 consecutive valid_in cycles into one 64-bit word, byte k (k=0..7, arrival order) in bits [8k+7:8k].
REQ-013 FSM SHALL have states IDLE and COLLECT, with a 3-bit byte counter.
- IDLE: valid_in=1 -> store byte 0, count=1, go COLLECT; else stay.
- COLLECT, valid_in=1: store byte at count; count 7 -> push word, count=0, go IDLE.
- COLLECT, valid_in=0: discard partial word, pulse err_short next cycle, count=0, go IDLE.
REQ-014 A valid_in high on the cycle after the 8th byte SHALL start a new frame with no dead cycle, so back-to-back bursts (16 consecutive bytes) yield 2 words.
REQ-015 The output SHALL be a 2-entry FIFO; push on the 8th-byte cycle N, word_valid high at cycle N+1 if the FIFO was empty (latency 1 cycle from last byte).
REQ-016 Pop SHALL occur on a cycle with word_valid=1 and word_ready=1; word_out then advances to the next entry, or word_valid drops if none remains.
REQ-017 A push when the FIFO holds 2 entries and no pop occurs that cycle SHALL drop the new word, keep both stored words, and pulse err_overflow next cycle.
REQ-018 A simultaneous push and pop with the FIFO full SHALL be accepted (occupancy stays 2, no overflow).
REQ-019 A simultaneous push and pop with the FIFO empty is impossible (word_valid=0); push SHALL be taken, and occupancy becomes 1.
REQ-020 word_ready while word_valid=0 SHALL have no effect.
REQ-021 err_short and err_overflow SHALL be registered, never high for two consecutive cycles from one event.

Reset
REQ-022 While rst=0: FSM=IDLE, count=0, FIFO empty, word_valid=0, word_out=0, err_short=0, err_overflow=0, word_chk=0.
REQ-023 Reset mid-frame or with words queued SHALL discard all partial and queued data without any error pulse.
REQ-024 The first frame SHALL be accepted starting at the first rising edge where rst=1 and valid_in=1.

Configuration
REQ-025 Macro BYTE_CHECKSUM_EN: when defined, each FIFO entry SHALL carry an 8-bit XOR of its bytes, presented on word_chk aligned with word_out (0 when word_valid=0).
REQ-026 Without BYTE_CHECKSUM_EN, port word_chk and its storage SHALL be absent; all other behaviour identical.

Verification
REQ-027 Bytes 0x11,0x22,...,0x88 on 8 consecutive cycles, word_ready=1 -> word_valid 1 cycle after the 8th byte, word_out=0x8877665544332211, word_chk=0x88 (with macro).
REQ-028 3 bytes then valid_in=0 -> err_short single pulse, no word_valid, next 8-byte burst forms a clean word.
REQ-029 24 consecutive bytes, word_ready=0 -> first 2 words held in order, third dropped, one err_overflow pulse; then word_ready=1 -> exactly 2 words popped.
REQ-030 FIFO full, word_ready=1 on the same cycle as the 8th byte of a new frame -> no err_overflow, occupancy stays 2, order preserved.
REQ-031 rst=0 after 5 bytes with 1 word queued -> all outputs 0; after release, a new 8-byte burst gives exactly one correct word.
